vga_timing_ctrl: RTL
====================

// Module: vga_timing_ctrl
// PURPOSE
//  Parametrised VGA raster controller that generalises the fixed-mode VGA block.
//  - Raster timing comes from per-field parameters; mode macros only supply the defaults.
//  - Generates hsync/vsync with configurable polarity, a data-enable and frame/line strobes.
//  - Drives an (x,y) pixel-request port into a frame buffer with fixed read latency.
//  - Outputs COLOR_BITS-per-channel RGB, aligned with sync and DE. Runs on a pixel clock-enable.
// PARAMETERS
//  H_SYNC      96   hsync pulse ticks
//  H_BP        48   horizontal back porch
//  H_LBORD     0    left border ticks
//  H_ACTIVE    640  addressable pixels per line
//  H_RBORD     0    right border ticks
//  H_FP        16   horizontal front porch
//  V_SYNC      2    vsync pulse lines; V_BP 33, V_TBORD 0, V_ACTIVE 480, V_BBORD 0, V_FP 10
//  H_SYNC_POL  0    active level of hsync_o (0 = active-low)
//  V_SYNC_POL  0    active level of vsync_o
//  COLOR_BITS  1    bits per colour channel (1..8)
//  BORDER_RGB  all ones  3*COLOR_BITS colour driven in border region
//  FETCH_LAT   1    ce-cycles from req_o to valid pix_data_i (0..4)
// PORTS
//  clk_i          in   1             clock
//  rst_i          in   1             reset, asynchronous, active-high
//  pix_ce_i       in   1             pixel tick enable; all state advances only when 1
//  req_o          out  1             pixel fetch request (addressable pixel)
//  x_o            out  clog2(H_ACTIVE)  addressable column of request
//  y_o            out  clog2(V_ACTIVE)  addressable row of request
//  pix_data_i     in   3*COLOR_BITS  {R,G,B} returned FETCH_LAT ce-cycles after req_o
//  red_o          out  COLOR_BITS    registered colour, likewise green_o / blue_o
//  hsync_o        out  1             registered hsync
//  vsync_o        out  1             registered vsync
//  de_o           out  1             registered addressable-video enable
//  frame_start_o  out  1             one ce-cycle pulse, output-aligned with h=0,v=0
//  line_start_o   out  1             one ce-cycle pulse, output-aligned with h=0
// BEHAVIOUR
//  - Counters: hcnt 0..H_TOTAL-1, vcnt 0..V_TOTAL-1, H_TOTAL = sum of H fields.
//    Region order per line: SYNC, BP, LBORD, ACTIVE, RBORD, FP (same order for V).
//  - On ce: hcnt wraps to 0 at H_TOTAL-1; vcnt advances only on hcnt wrap and wraps at V_TOTAL-1.
//  - Sync is a pure decode of the current counters, including the wrap tick (no stale level at wrap).
//  - req_o is combinational from the counters: 1 iff hcnt and vcnt are both in ACTIVE.
//    x_o = hcnt-(H_SYNC+H_BP+H_LBORD); y_o likewise from vcnt. x_o/y_o are 0 when req_o=0.
//  - Alignment: a delay line of FETCH_LAT ce-stages carries {hs, vs, de, border, visible, fs, ls}.
//    Output registers load on ce from the delay-line tap and pix_data_i.
//    Total latency counter->outputs = FETCH_LAT+1 ce-cycles.
//  - Colour select at the output register: de -> pix_data_i; border -> BORDER_RGB; else 0 (blanking).
//  - pix_ce_i=0: counters, delay line and outputs hold; pix_data_i is ignored on that cycle.
//    The frame buffer must hold its data across stalls.
//  - Reset (any time, mid-line included): counters 0, delay line cleared to blank.
//    Outputs on reset: colour 0, de_o 0, hsync_o=~H_SYNC_POL, vsync_o=~V_SYNC_POL, strobes 0.
//    First sync edge appears FETCH_LAT+1 ce-cycles after reset release.
//  - Elaboration error if any *_ACTIVE=0, *_SYNC=0 or FETCH_LAT>4.
// STRUCTURE
//  - vga.vh gains per-mode timing defaults (field macros) and a MODE-to-parameter mapping.
//  - common.vh supplies a CLOG2_MIN1 width helper so a 1-wide field still gets a 1-bit port.
//  - One sub-module: vga_delay_line, a WIDTH x DEPTH shift register with ce and async reset.
//    DEPTH=0 makes it a pass-through.
//  - Counter/decode logic and the output register stay in this module.
// TESTING (small mode: H 2/1/1/4/1/1 = 10, V 1/1/0/3/0/1 = 6, COLOR_BITS=4, FETCH_LAT=2)
//  1. Free-run with ce=1 -> hsync_o low 2 of every 10 cycles, first low at cycle 3 after reset release.
//     vsync_o low for 10 cycles every 60; frame_start_o period 60.
//  2. Frame-buffer model returning {x,y,x^y} -> de_o high 4 cycles per active line, 3 lines/frame.
//     Colour equals the model value for the matching (x,y); req_o count = 12 per frame.
//  3. Border check -> tick between BP and ACTIVE, and after ACTIVE, output 12'hFFF with de_o=0.
//     Sync/porch ticks output 0.
//  4. ce pattern 1,0,0,1 (random) -> waveform equals the ce=1 run sampled on ce cycles.
//     No output changes while ce=0.
//  5. Assert rst_i mid-active line, release -> outputs at reset values immediately (async).
//     Timing then restarts exactly as in test 1.
//  6. H_SYNC_POL=V_SYNC_POL=1, FETCH_LAT=0 -> syncs active-high, latency 1 cycle, colour still aligned.

Source files
------------

// File: rtl/vga_timing_ctrl_pkg.sv
// Shared types, 640x480@60 timing defaults and width helper for the VGA raster controller.
package vga_timing_ctrl_pkg;

    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_LBORD  = 0;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_RBORD  = 0;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TBORD  = 0;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_BBORD  = 0;
    localparam int VGA_V_FP     = 10;

    // Control bits that travel alongside the frame-buffer fetch.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic border;
        logic fs;
        logic ls;
    } vga_ctl_t;

    // Width of a field holding 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register advancing on ce, cleared by async reset; DEPTH=0 is a wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = &{1'b0, clk_i, rst_i, ce_i};
            assign dout_o    = din_i;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

            always_comb begin
                stage_d = stage_q;
                if (ce_i) begin
                    stage_d[0] = din_i;
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) stage_q <= '0;
                else       stage_q <= stage_d;
            end

            assign dout_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// Parametrised VGA raster controller: counters, region decode, frame-buffer request port,
// and an output register aligned to the fetch latency through vga_delay_line.
module vga_timing_ctrl
    import vga_timing_ctrl_pkg::*;
#(
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int H_LBORD    = VGA_H_LBORD,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_RBORD    = VGA_H_RBORD,
    parameter int H_FP       = VGA_H_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int V_TBORD    = VGA_V_TBORD,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_BBORD    = VGA_V_BBORD,
    parameter int V_FP       = VGA_V_FP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int COLOR_BITS = 1,
    parameter logic [3*COLOR_BITS-1:0] BORDER_RGB = '1,
    parameter int FETCH_LAT  = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              pix_ce_i,
    output logic                              req_o,
    output logic [clog2_min1(H_ACTIVE)-1:0]   x_o,
    output logic [clog2_min1(V_ACTIVE)-1:0]   y_o,
    input  logic [3*COLOR_BITS-1:0]           pix_data_i,
    output logic [COLOR_BITS-1:0]             red_o,
    output logic [COLOR_BITS-1:0]             green_o,
    output logic [COLOR_BITS-1:0]             blue_o,
    output logic                              hsync_o,
    output logic                              vsync_o,
    output logic                              de_o,
    output logic                              frame_start_o,
    output logic                              line_start_o
);

    localparam int X_W     = clog2_min1(H_ACTIVE);
    localparam int Y_W     = clog2_min1(V_ACTIVE);
    localparam int H_TOTAL = H_SYNC + H_BP + H_LBORD + H_ACTIVE + H_RBORD + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_TBORD + V_ACTIVE + V_BBORD + V_FP;
    localparam int H_VIS0  = H_SYNC + H_BP;
    localparam int H_ACT0  = H_VIS0 + H_LBORD;
    localparam int H_ACT1  = H_ACT0 + H_ACTIVE;
    localparam int H_VIS1  = H_ACT1 + H_RBORD;
    localparam int V_VIS0  = V_SYNC + V_BP;
    localparam int V_ACT0  = V_VIS0 + V_TBORD;
    localparam int V_ACT1  = V_ACT0 + V_ACTIVE;
    localparam int V_VIS1  = V_ACT1 + V_BBORD;
    // One spare count of headroom so region bounds equal to the total still fit.
    localparam int HC_W    = clog2_min1(H_TOTAL + 1);
    localparam int VC_W    = clog2_min1(V_TOTAL + 1);

    generate
        if (H_ACTIVE <= 0 || V_ACTIVE <= 0 || H_SYNC <= 0 || V_SYNC <= 0 ||
            FETCH_LAT < 0 || FETCH_LAT > 4 || COLOR_BITS < 1 || COLOR_BITS > 8) begin : g_bad_cfg
            $error("vga_timing_ctrl: illegal timing/latency/colour parameters");
        end
    endgenerate

    logic [HC_W-1:0] hcnt_q, hcnt_d;
    logic [VC_W-1:0] vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_ce_i) begin
            if (hcnt_q == HC_W'(H_TOTAL - 1)) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == VC_W'(V_TOTAL - 1)) ? '0 : vcnt_q + VC_W'(1);
            end else begin
                hcnt_d = hcnt_q + HC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Pure decode of the live counters, so the wrap tick already carries the new region.
    logic h_act, v_act, h_vis, v_vis;
    vga_ctl_t ctl_in, ctl_tap;

    assign h_act = (hcnt_q >= HC_W'(H_ACT0)) && (hcnt_q < HC_W'(H_ACT1));
    assign v_act = (vcnt_q >= VC_W'(V_ACT0)) && (vcnt_q < VC_W'(V_ACT1));
    assign h_vis = (hcnt_q >= HC_W'(H_VIS0)) && (hcnt_q < HC_W'(H_VIS1));
    assign v_vis = (vcnt_q >= VC_W'(V_VIS0)) && (vcnt_q < VC_W'(V_VIS1));

    assign req_o = h_act && v_act;
    assign x_o   = req_o ? X_W'(hcnt_q - HC_W'(H_ACT0)) : '0;
    assign y_o   = req_o ? Y_W'(vcnt_q - VC_W'(V_ACT0)) : '0;

    always_comb begin
        ctl_in        = '0;
        ctl_in.hs     = hcnt_q < HC_W'(H_SYNC);
        ctl_in.vs     = vcnt_q < VC_W'(V_SYNC);
        ctl_in.de     = req_o;
        ctl_in.border = h_vis && v_vis && !req_o;
        ctl_in.ls     = hcnt_q == '0;
        ctl_in.fs     = (hcnt_q == '0) && (vcnt_q == '0);
    end

    vga_delay_line #(
        .WIDTH ($bits(vga_ctl_t)),
        .DEPTH (FETCH_LAT)
    ) u_dly (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .ce_i   (pix_ce_i),
        .din_i  (ctl_in),
        .dout_o (ctl_tap)
    );

    logic [3*COLOR_BITS-1:0] rgb_q, rgb_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d, ls_q, ls_d;

    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        fs_d    = fs_q;
        ls_d    = ls_q;
        if (pix_ce_i) begin
            rgb_d = '0;
            if (ctl_tap.de)          rgb_d = pix_data_i;
            else if (ctl_tap.border) rgb_d = BORDER_RGB;
            hsync_d = ctl_tap.hs ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_d = ctl_tap.vs ? V_SYNC_POL : ~V_SYNC_POL;
            de_d    = ctl_tap.de;
            fs_d    = ctl_tap.fs;
            ls_d    = ctl_tap.ls;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rgb_q   <= '0;
            hsync_q <= ~H_SYNC_POL;
            vsync_q <= ~V_SYNC_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
        end
    end

    assign {red_o, green_o, blue_o} = rgb_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign frame_start_o = fs_q;
    assign line_start_o  = ls_q;

endmodule
